// File: rtl/y86_dmem_responder_if.sv
// Request/response bundle between the Y86-64 M-stage and its data memory.
// master = pipeline side, slave = memory responder.
interface y86_dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/y86_dmem_responder.sv
// Fixed-latency little-endian 8-byte data memory for the Y86-64 pipeline.
// One request outstanding at a time; out-of-range accesses report resp_err.
module y86_dmem_responder #(
  parameter int unsigned MEM_BYTES = 8192,
  parameter int unsigned LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  y86_dmem_responder_if.slave  bus
);

  localparam int unsigned AW = $clog2(MEM_BYTES);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        ready;
  logic        accept;
  logic        fire;
  logic        addr_err;
  logic [63:0] rd_word;
  logic [AW-1:0] byte_idx [8];

  logic [7:0] mem [MEM_BYTES];

  // Unsigned 64-bit compare: addresses near 2^64 must not wrap into range.
  assign addr_err = addr_q > 64'(MEM_BYTES - 8);
  assign fire     = (state_q == BUSY) && (cnt_q == 4'd1);
  assign ready    = (state_q != BUSY);
  assign accept   = bus.req_valid && ready;

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < 8; i++) begin
      byte_idx[i] = addr_q[AW-1:0] + AW'(i);
      rd_word[8*i +: 8] = mem[byte_idx[i]];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      IDLE: if (accept) state_d = BUSY;
      BUSY: begin
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          err_d   = addr_err;
          rdata_d = (addr_err || wr_q) ? '0 : rd_word;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = accept ? BUSY : IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      wr_d    = bus.req_write;
      addr_d  = bus.req_addr;
      wdata_d = bus.req_wdata;
      cnt_d   = 4'(LATENCY);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage survives reset; a store dropped by reset never reaches it.
  always_ff @(posedge clk) begin
    if (!reset && fire && wr_q && !addr_err) begin
      for (int i = 0; i < 8; i++) mem[byte_idx[i]] <= wdata_q[8*i +: 8];
    end
  end

  always_comb begin
    bus.req_ready  = ready;
    bus.resp_valid = (state_q == RESP);
    bus.resp_rdata = rdata_q;
    bus.resp_err   = err_q;
  end

endmodule

// File: tb/tb_y86_dmem_responder.sv
// Directed bench: LATENCY=2 instance (sel=0) and LATENCY=1 instance (sel=1)
// share one request driver; outputs are muxed back by sel.
module tb_y86_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        v, w;
  logic [63:0] a, d;

  int n_vec = 0;
  int n_bad = 0;

  logic [63:0] s_addr [3];
  logic [63:0] s_exp  [3];

  y86_dmem_responder_if bus0 ();
  y86_dmem_responder_if bus1 ();

  assign bus0.req_valid = v & ~sel;
  assign bus1.req_valid = v & sel;
  assign bus0.req_write = w;
  assign bus1.req_write = w;
  assign bus0.req_addr  = a;
  assign bus1.req_addr  = a;
  assign bus0.req_wdata = d;
  assign bus1.req_wdata = d;

  wire        rdy = sel ? bus1.req_ready  : bus0.req_ready;
  wire        rv  = sel ? bus1.resp_valid : bus0.resp_valid;
  wire [63:0] rd  = sel ? bus1.resp_rdata : bus0.resp_rdata;
  wire        er  = sel ? bus1.resp_err   : bus0.resp_err;

  y86_dmem_responder #(.MEM_BYTES(8192), .LATENCY(2)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave));
  y86_dmem_responder #(.MEM_BYTES(8192), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // One request; returns response fields and latency in edges after accept.
  task automatic xact(input logic wr, input logic [63:0] ad, input logic [63:0] wd,
                      output logic [63:0] rdata, output logic err, output int lat);
    int n;
    @(negedge clk);
    w = wr; a = ad; d = wd; v = 1'b1;
    n = 0;
    while (!rdy && n < 20) begin @(negedge clk); n++; end
    if (!rdy) chk("ready_timeout", {63'd0, rdy}, 64'd1);
    @(posedge clk);
    #1 v = 1'b0; w = ~wr; a = ~ad; d = ~wd;
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rv) begin lat = k; break; end
    end
    if (lat < 0) chk("resp_timeout", {63'd0, rv}, 64'd1);
    rdata = rd;
    err   = er;
  endtask

  // Holds req_valid for nacc loads from s_addr; records ready/resp per cycle.
  task automatic stream(input int nacc, input int len,
                        output logic [15:0] rdy_v, output logic [15:0] rsp_v);
    int acc, nrsp;
    acc = 0; nrsp = 0; rdy_v = '0; rsp_v = '0;
    @(negedge clk);
    w = 1'b0; a = s_addr[0]; v = 1'b1;
    for (int j = 0; j < len; j++) begin
      rdy_v[j] = rdy;
      rsp_v[j] = rv;
      if (rv && nrsp < 3) begin
        chk($sformatf("stream_rdata%0d", nrsp), rd, s_exp[nrsp]);
        nrsp++;
      end
      if (v && rdy) acc++;
      @(posedge clk);
      #1 if (acc >= nacc) v = 1'b0; else a = s_addr[acc];
      @(negedge clk);
    end
    v = 1'b0;
  endtask

  logic [63:0] r;
  logic        e;
  int          lat;
  logic [15:0] rv_v, rs_v;
  int          seen;

  initial begin
    v = 0; w = 0; a = '0; d = '0; sel = 0; reset = 1;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_ready",  {63'd0, rdy}, 64'd1);
    chk("rst_rvalid", {63'd0, rv},  64'd0);
    chk("rst_rdata",  rd, 64'd0);
    chk("rst_err",    {63'd0, er},  64'd0);

    // basic load after preload store
    xact(1, 64'h0, 64'h0807060504030201, r, e, lat);
    chk("st0_lat", 64'(lat), 64'd2);
    chk("st0_rdata", r, 64'd0);
    xact(0, 64'h0, 64'h0, r, e, lat);
    chk("ld0_lat", 64'(lat), 64'd2);
    chk("ld0_rdata", r, 64'h0807060504030201);
    chk("ld0_err", {63'd0, e}, 64'd0);

    // unaligned store overlapping two zeroed words
    xact(1, 64'h10, 64'h0, r, e, lat);
    xact(1, 64'h18, 64'h0, r, e, lat);
    xact(1, 64'h13, 64'h1122334455667788, r, e, lat);
    xact(0, 64'h10, 64'h0, r, e, lat);
    chk("ld10_rdata", r, 64'h4455667788000000);
    xact(0, 64'h18, 64'h0, r, e, lat);
    chk("ld18_rdata", r, 64'h0000000000112233);
    xact(0, 64'h13, 64'h0, r, e, lat);
    chk("ld13_rdata", r, 64'h1122334455667788);

    // range boundary
    xact(1, 64'd8184, 64'hDEADBEEFCAFEF00D, r, e, lat);
    chk("st8184_err", {63'd0, e}, 64'd0);
    xact(0, 64'd8185, 64'h0, r, e, lat);
    chk("ld8185_err", {63'd0, e}, 64'd1);
    chk("ld8185_rdata", r, 64'd0);
    xact(0, 64'hFFFFFFFFFFFFFFFC, 64'h0, r, e, lat);
    chk("ldwrap_err", {63'd0, e}, 64'd1);
    chk("ldwrap_rdata", r, 64'd0);
    xact(1, 64'd8185, 64'h5555555555555555, r, e, lat);
    chk("st8185_err", {63'd0, e}, 64'd1);
    xact(0, 64'd8184, 64'h0, r, e, lat);
    chk("ld8184_err", {63'd0, e}, 64'd0);
    chk("ld8184_rdata", r, 64'hDEADBEEFCAFEF00D);

    // continuous valid: accepts at edges 0,3,6
    s_addr[0] = 64'h0;  s_exp[0] = 64'h0807060504030201;
    s_addr[1] = 64'd8184; s_exp[1] = 64'hDEADBEEFCAFEF00D;
    s_addr[2] = 64'h13; s_exp[2] = 64'h1122334455667788;
    stream(3, 11, rv_v, rs_v);
    chk("stream_ready", 64'(rv_v), 64'h0649);
    chk("stream_resp",  64'(rs_v), 64'h0248);

    // reset during an in-flight store
    xact(1, 64'h40, 64'h0, r, e, lat);
    xact(0, 64'h0, 64'h0, r, e, lat);
    @(negedge clk);
    w = 1; a = 64'h40; d = 64'hAAAAAAAAAAAAAAAA; v = 1;
    @(posedge clk);
    #1 v = 0;
    @(negedge clk);
    reset = 1;
    @(posedge clk);
    #1 reset = 0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rv) seen++;
    end
    chk("rst_noresp", 64'(seen), 64'd0);
    chk("rst2_ready", {63'd0, rdy}, 64'd1);
    chk("rst2_rdata", rd, 64'd0);
    xact(0, 64'h40, 64'h0, r, e, lat);
    chk("ld40_rdata", r, 64'h0);

    // LATENCY=1 instance
    sel = 1;
    xact(1, 64'h100, 64'h0123456789ABCDEF, r, e, lat);
    xact(1, 64'h108, 64'h0, r, e, lat);
    xact(0, 64'h100, 64'h0, r, e, lat);
    chk("l1_lat", 64'(lat), 64'd1);
    chk("l1_rdata", r, 64'h0123456789ABCDEF);
    s_addr[0] = 64'h100; s_exp[0] = 64'h0123456789ABCDEF;
    s_addr[1] = 64'h101; s_exp[1] = 64'h000123456789ABCD;
    stream(2, 6, rv_v, rs_v);
    chk("l1_stream_ready", 64'(rv_v), 64'h0035);
    chk("l1_stream_resp",  64'(rs_v), 64'h0014);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
